// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the read-only SPI flash controller.
package spi_flash_pkg;

    // Controller sequencing: one command frame per granted request.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        GAP
    } state_t;

    // Standard serial-flash READ opcode (no dummy cycles).
    localparam logic [7:0] CMD_READ = 8'h03;

    // One frame: 8 command bits, 24 address bits, 32 data bits.
    localparam int XFER_BITS = 64;

    // Bit counter width; it wraps naturally from 63 back to 0.
    localparam int BIT_CNT_W = 6;

    // Flash returns bytes lowest address first; the core wants little-endian words.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Full outgoing frame; the trailing zeros are clocked out while data comes back.
    function automatic logic [XFER_BITS-1:0] read_frame(input logic [23:0] addr);
        return {CMD_READ, addr, 32'h0000_0000};
    endfunction

endpackage

// File: rtl/spi_flash_shifter.sv
// SPI mode-0 bit engine: divides clk down to sck, shifts a 64-bit frame out
// on sdo MSB-first and collects sdi into the same register as bits leave it.
module spi_flash_shifter
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [XFER_BITS-1:0] shift_word,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          rx_word,
    output logic                 sck,
    output logic                 sdo,
    input  logic                 sdi
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(XFER_BITS - 1);

    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [XFER_BITS-1:0] shift_reg;
    logic                 sck_q;
    logic                 busy_q;
    logic                 sample_q;
    logic                 phase_end;
    logic                 sck_fall;
    logic                 sample_now;
    logic                 rx_bit;

    // Decode where we are inside the current sck half-period.
    always_comb begin
        phase_end  = busy_q && (div_cnt == DIV_LAST);
        sck_fall   = phase_end && sck_q;
        sample_now = busy_q && sck_q && (div_cnt == '0);
        // With CLK_DIV=1 the sample and the falling edge share a cycle, so
        // the freshly sampled bit must bypass sample_q.
        rx_bit     = sample_now ? sdi : sample_q;
    end

    // Divider, sck toggling, sdi capture and frame shifting.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, as real hardware does.
        if (reset) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            sck_q     <= 1'b0;
            busy_q    <= 1'b0;
            sample_q  <= 1'b0;
        end else if (!busy_q) begin
            if (start) begin
                shift_reg <= shift_word;
                busy_q    <= 1'b1;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                sck_q     <= 1'b0;
            end
        end else begin
            if (sample_now) begin
                sample_q <= sdi;
            end
            if (phase_end) begin
                div_cnt <= '0;
                sck_q   <= ~sck_q;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            // Falling sck: next MOSI bit moves to the MSB, sampled MISO bit enters at the LSB.
            if (sck_fall) begin
                shift_reg <= {shift_reg[XFER_BITS-2:0], rx_bit};
                bit_cnt   <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    // Last cycle of the last bit; the frame register holds all 64 samples one edge later.
    assign done    = sck_fall && (bit_cnt == LAST_BIT);
    assign busy    = busy_q;
    assign sck     = sck_q;
    assign sdo     = busy_q & shift_reg[XFER_BITS-1];
    assign rx_word = shift_reg[31:0];

endmodule

// File: rtl/spi_flash_reader.sv
// Read-only SPI flash controller: round-robin arbitration between the
// instruction-fetch port (0) and the data-load port (1); each grant runs one
// READ frame and returns a little-endian 32-bit word.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int          CLK_DIV      = 2,
    parameter logic [23:0] FLASH_OFFSET = 24'h200000,
    parameter int          CS_HIGH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [23:0] req_addr0,
    input  logic [23:0] req_addr1,
    output logic [1:0]  resp_ready,
    output logic [31:0] resp_rdata,
    output logic        sck,
    output logic        sdo,
    input  logic        sdi,
    output logic        cs
);

    localparam int GAP_W = (CS_HIGH > 2) ? $clog2(CS_HIGH - 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_HIGH >= 2) ? (CS_HIGH - 2) : 0);

    state_t               state;
    state_t               state_next;
    logic                 last_grant;
    logic                 grant_valid;
    logic                 grant_port;
    logic [21:0]          sel_word;
    logic [23:0]          flash_addr;
    logic [XFER_BITS-1:0] frame;
    logic [GAP_W-1:0]     gap_cnt;
    logic [31:0]          rdata_q;
    logic                 start;
    logic                 sh_busy;
    logic                 sh_done;
    logic [31:0]          sh_rx_word;
    logic                 unused_addr_bits;

    // Requests are word-aligned; the byte-offset bits carry no meaning here.
    assign unused_addr_bits = ^{req_addr0[1:0], req_addr1[1:0]};

    // Round-robin arbiter and flash address arithmetic (24-bit, wraps silently).
    always_comb begin
        grant_valid = |req_valid;
        grant_port  = 1'b0;
        if (req_valid == 2'b11) begin
            grant_port = ~last_grant;
        end else begin
            grant_port = req_valid[1];
        end
        sel_word   = grant_port ? req_addr1[23:2] : req_addr0[23:2];
        flash_addr = {sel_word, 2'b00} + FLASH_OFFSET;
        frame      = read_frame(flash_addr);
    end

    // Next-state logic: IDLE -> SHIFT -> DONE -> GAP -> IDLE.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves a signal unassigned and no latch is inferred.
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    start      = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (sh_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = (CS_HIGH > 1) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, grant history, cs-high gap counter and held read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gap_cnt    <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_valid) begin
                last_grant <= grant_port;
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
            if (state == DONE) begin
                rdata_q <= byte_swap(sh_rx_word);
            end
        end
    end

    spi_flash_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .shift_word(frame),
        .busy      (sh_busy),
        .done      (sh_done),
        .rx_word   (sh_rx_word),
        .sck       (sck),
        .sdo       (sdo),
        .sdi       (sdi)
    );

    // The shifter is busy for exactly the SHIFT state, so it frames cs directly.
    assign cs = ~sh_busy;

    // Response mux: fresh word in the DONE cycle, the held copy afterwards.
    assign resp_ready = (state == DONE) ? (last_grant ? 2'b10 : 2'b01) : 2'b00;
    assign resp_rdata = (state == DONE) ? byte_swap(sh_rx_word) : rdata_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a behavioural serial flash answers READ frames
// from a computed byte pattern, a protocol monitor watches the SPI pins, and
// directed plus random requests are compared against rule-level expectations.
module tb_spi_flash_reader;

    localparam int          CLK_DIV  = 2;
    localparam logic [23:0] OFFSET   = 24'h200000;
    localparam int          CS_HIGH  = 2;
    localparam int          LATENCY  = 128 * CLK_DIV;
    localparam int          TIMEOUT  = 4 * (LATENCY + 20);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [23:0] req_addr0 = '0;
    logic [23:0] req_addr1 = '0;
    logic [1:0]  resp_ready;
    logic [31:0] resp_rdata;
    logic        sck;
    logic        sdo;
    logic        sdi = 1'b0;
    logic        cs;

    int errors = 0;
    int checks = 0;

    spi_flash_reader #(
        .CLK_DIV     (CLK_DIV),
        .FLASH_OFFSET(OFFSET),
        .CS_HIGH     (CS_HIGH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .sck       (sck),
        .sdo       (sdo),
        .sdi       (sdi),
        .cs        (cs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Firmware image content: a fixed scramble of the byte address.
    function automatic logic [7:0] byte_at(input logic [23:0] a);
        logic [7:0] lo;
        lo = a[7:0] * 8'd29;
        return lo ^ a[15:8] ^ (a[23:16] + 8'h5A);
    endfunction

    function automatic logic [23:0] flash_addr(input logic [23:0] a);
        return (a & 24'hFFFFFC) + OFFSET;
    endfunction

    // Little-endian word built from four consecutive flash bytes.
    function automatic logic [31:0] model_word(input logic [23:0] fa);
        return {byte_at(fa + 24'd3), byte_at(fa + 24'd2), byte_at(fa + 24'd1), byte_at(fa)};
    endfunction

    // ---------------- flash model and protocol monitor ----------------
    int          mon_rises = 0;
    int          hi_run = 0;
    int          viol = 0;
    int          mon_k;
    logic [31:0] mon_hdr = '0;
    logic [7:0]  obs_cmd = '0;
    logic [23:0] obs_addr = '0;
    logic [7:0]  mon_byte;
    logic        m_prev_cs = 1'b1;
    logic        m_prev_sck = 1'b0;
    logic        m_prev_sdo = 1'b0;
    logic        abort_pending = 1'b0;
    logic        gap_skip = 1'b0;

    // Sample pins mid-cycle; act like a mode-0 flash and police the bus.
    always @(negedge clk) begin
        if (cs === 1'b1 && sck === 1'b1) viol++;
        if (cs === 1'b0 && sck === 1'b1 && m_prev_sck === 1'b1 && sdo !== m_prev_sdo) viol++;
        if (m_prev_cs === 1'b1 && cs === 1'b0) begin
            if (gap_skip) gap_skip = 1'b0;
            else check("cs_gap", 32'(hi_run >= CS_HIGH), 32'd1);
            mon_rises = 0;
            mon_hdr   = '0;
        end
        if (cs === 1'b1) hi_run++;
        else hi_run = 0;
        if (cs === 1'b0) begin
            if (sck === 1'b1 && m_prev_sck === 1'b0) begin
                mon_rises++;
                if (mon_rises <= 32) mon_hdr = {mon_hdr[30:0], sdo};
                if (mon_rises == 32) begin
                    obs_cmd  = mon_hdr[31:24];
                    obs_addr = mon_hdr[23:0];
                end
            end
            if (sck === 1'b0 && m_prev_sck === 1'b1) begin
                if (mon_rises >= 32 && mon_rises < 64) begin
                    mon_k    = mon_rises - 32;
                    mon_byte = byte_at(obs_addr + 24'(mon_k / 8));
                    sdi      = mon_byte[7 - (mon_k % 8)];
                end else begin
                    sdi = 1'($urandom);
                end
            end
        end
        if (m_prev_cs === 1'b0 && cs === 1'b1) begin
            if (abort_pending) begin
                abort_pending = 1'b0;
                gap_skip      = 1'b1;
            end else begin
                check("sck_rises", mon_rises, 32'd64);
            end
        end
        m_prev_cs  = cs;
        m_prev_sck = sck;
        m_prev_sdo = sdo;
    end

    // ---------------- stimulus ----------------
    logic        lg = 1'b1;
    logic [31:0] last_word = '0;

    // Raise the requested ports and serve them; the expected winner follows
    // the round-robin rule applied to the still-pending ports.
    task automatic issue(input logic [1:0] ports, input logic [23:0] a0, input logic [23:0] a1);
        logic [1:0]  pend;
        logic        prev_cs;
        logic        port;
        logic [23:0] fa;
        logic [31:0] exp_word;
        int          cyc;
        int          start_cyc;
        pend      = ports;
        req_addr0 = a0;
        req_addr1 = a1;
        req_valid = ports;
        prev_cs   = cs;
        cyc       = 0;
        start_cyc = 0;
        while (pend != 2'b00 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
            if (prev_cs === 1'b1 && cs === 1'b0) start_cyc = cyc;
            prev_cs = cs;
            if (resp_ready !== 2'b00) begin
                port     = (pend == 2'b11) ? ~lg : pend[1];
                fa       = flash_addr(port ? a1 : a0);
                exp_word = model_word(fa);
                check("resp_ready", 32'(resp_ready), port ? 32'd2 : 32'd1);
                check("resp_rdata", resp_rdata, exp_word);
                check("flash_cmd", 32'(obs_cmd), 32'h03);
                check("flash_addr", 32'(obs_addr), 32'(fa));
                check("latency", cyc - start_cyc, LATENCY);
                last_word       = exp_word;
                lg              = port;
                pend[port]      = 1'b0;
                req_valid[port] = 1'b0;
            end
        end
        check("served_before_timeout", 32'(pend), 32'd0);
    endtask

    initial begin
        int          cyc;
        logic [1:0]  ports;
        logic [23:0] ra0;
        logic [23:0] ra1;

        // Reset values.
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_sdo", 32'(sdo), 32'd0);
        check("rst_resp_ready", 32'(resp_ready), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        reset = 1'b0;
        lg    = 1'b1;
        @(negedge clk);

        // Single fetch, unaligned load, wrap past 2^24, top of range.
        issue(2'b01, 24'h000000, 24'h000000);
        issue(2'b10, 24'h000000, 24'h000013);
        issue(2'b01, 24'hE00010, 24'h000000);
        issue(2'b10, 24'h000000, 24'hFFFFFF);

        // Held data after the completion.
        repeat (20) @(negedge clk);
        check("rdata_held", resp_rdata, last_word);

        // Contention from reset release: 0,1,0,1.
        reset     = 1'b1;
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lg    = 1'b1;
        issue(2'b11, 24'h000100, 24'h000204);
        issue(2'b11, 24'h000308, 24'h00040C);

        // Randomised requests.
        for (int i = 0; i < 6; i++) begin
            ports = 2'($urandom_range(1, 3));
            ra0   = 24'($urandom);
            ra1   = 24'($urandom);
            issue(ports, ra0, ra1);
        end

        // Reset part-way through a port 0 transfer.
        req_addr0 = 24'($urandom);
        req_valid = 2'b01;
        cyc = 0;
        while (cs !== 1'b0 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        while (mon_rises < 30 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_point_reached", 32'(mon_rises >= 30), 32'd1);
        abort_pending = 1'b1;
        reset         = 1'b1;
        req_valid     = 2'b11;
        @(negedge clk);
        check("abort_cs", 32'(cs), 32'd1);
        check("abort_sck", 32'(sck), 32'd0);
        check("abort_resp_ready", 32'(resp_ready), 32'd0);
        reset = 1'b0;
        lg    = 1'b1;
        issue(2'b11, req_addr0, 24'($urandom));

        repeat (10) @(negedge clk);
        check("protocol_violations", viol, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
